// File: rtl/recursion_pkg.sv
// Shared definitions for the recursion frame stack: flag encodings and frame layout.
package recursion_pkg;

    localparam int FLAG_W = 2;

    localparam logic [FLAG_W-1:0] FLG_CALL = 2'b00;
    localparam logic [FLAG_W-1:0] FLG_INIT = 2'b01;
    localparam logic [FLAG_W-1:0] FLG_RET0 = 2'b10;
    localparam logic [FLAG_W-1:0] FLG_RET1 = 2'b11;

    // Frame layout for the default 8-bit datapath; wider datapaths use frame_w().
    localparam int DW_DEF  = 8;
    localparam int FRAME_W = FLAG_W + 2 * DW_DEF;

    typedef struct packed {
        logic [FLAG_W-1:0] flag;
        logic [DW_DEF-1:0] m;
        logic [DW_DEF-1:0] n;
    } frame_t;

    function automatic int frame_w(input int dw);
        return FLAG_W + 2 * dw;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Frame storage: one synchronous write port, one asynchronous read port, contents not reset.
module stack_mem #(
    parameter int W     = 18,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/recursion_stack.sv
// LIFO frame store for the recursion controller: pointer, sticky errors and depth watermark.
module recursion_stack
    import recursion_pkg::*;
#(
    parameter  int DW    = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic              top,
    input  logic [FLAG_W-1:0] flag_in,
    input  logic [DW-1:0]     din_m,
    input  logic [DW-1:0]     din_n,
    output logic [FLAG_W-1:0] flag_out,
    output logic [DW-1:0]     dout_m,
    output logic [DW-1:0]     dout_n,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       depth,
    output logic [AW:0]       max_depth,
    output logic              ovf,
    output logic              udf
);

    localparam int          W_FRAME = FLAG_W + 2 * DW;
    localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] SP_ONE  = (AW+1)'(1);

    logic [AW:0]        r_sp;
    logic [AW:0]        r_max;
    logic               r_ovf;
    logic               r_udf;

    logic [AW:0]        w_sp_nxt;
    logic               w_we;
    logic [AW-1:0]      w_waddr;
    logic [AW-1:0]      w_raddr;
    logic [W_FRAME-1:0] w_rdata;
    logic               w_ovf_set;
    logic               w_udf_set;
    logic               w_empty;
    logic               w_full;

    assign w_empty = (r_sp == '0);
    assign w_full  = (r_sp == SP_FULL);
    // At sp==DEPTH the low bits are zero, so the AW-bit decrement still lands on DEPTH-1.
    assign w_raddr = r_sp[AW-1:0] - AW'(1);

    always_comb begin
        w_sp_nxt  = r_sp;
        w_we      = 1'b0;
        w_waddr   = r_sp[AW-1:0];
        w_ovf_set = 1'b0;
        w_udf_set = 1'b0;
        if (clr) begin
            w_sp_nxt = '0;
        end else begin
            if (push && pop) begin
                w_we = 1'b1;
                if (w_empty) begin
                    w_waddr   = '0;
                    w_sp_nxt  = SP_ONE;
                    w_udf_set = 1'b1;
                end else begin
                    w_waddr = w_raddr;
                end
            end else if (push) begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_we     = 1'b1;
                    w_sp_nxt = r_sp + SP_ONE;
                end
            end else if (pop) begin
                if (w_empty) begin
                    w_udf_set = 1'b1;
                end else begin
                    w_sp_nxt = r_sp - SP_ONE;
                end
            end
            if (top && w_empty) begin
                w_udf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sp  <= '0;
            r_max <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_sp <= w_sp_nxt;
            if (w_sp_nxt > r_max) begin
                r_max <= w_sp_nxt;
            end
            if (clr) begin
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end else begin
                r_ovf <= r_ovf | w_ovf_set;
                r_udf <= r_udf | w_udf_set;
            end
        end
    end

    stack_mem #(
        .W     (W_FRAME),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata ({flag_in, din_m, din_n}),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        flag_out = '0;
        dout_m   = '0;
        dout_n   = '0;
        if (!w_empty) begin
            {flag_out, dout_m, dout_n} = w_rdata;
        end
    end

    assign empty     = w_empty;
    assign full      = w_full;
    assign depth     = r_sp;
    assign max_depth = r_max;
    assign ovf       = r_ovf;
    assign udf       = r_udf;

endmodule

// File: tb/tb_recursion_stack.sv
// Directed bench for recursion_stack with DW=8, DEPTH=16.
module tb_recursion_stack;
    import recursion_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr, push, pop, top;
    logic [1:0] flag_in;
    logic [7:0] din_m, din_n;
    logic [1:0] flag_out;
    logic [7:0] dout_m, dout_n;
    logic       empty, full;
    logic [4:0] depth, max_depth;
    logic       ovf, udf;

    int n_err = 0;
    int n_chk = 0;

    recursion_stack #(.DW(8), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push      (push),
        .pop       (pop),
        .top       (top),
        .flag_in   (flag_in),
        .din_m     (din_m),
        .din_n     (din_n),
        .flag_out  (flag_out),
        .dout_m    (dout_m),
        .dout_n    (dout_n),
        .empty     (empty),
        .full      (full),
        .depth     (depth),
        .max_depth (max_depth),
        .ovf       (ovf),
        .udf       (udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_top(input string tag, input logic [1:0] f, input logic [7:0] m, input logic [7:0] n);
        chk({tag, ".flag"}, 32'(flag_out), 32'(f));
        chk({tag, ".m"},    32'(dout_m),   32'(m));
        chk({tag, ".n"},    32'(dout_n),   32'(n));
    endtask

    // Apply one command for one clock, then sample 1 time unit after the edge.
    task automatic cyc(input logic c_clr, input logic c_push, input logic c_pop, input logic c_top,
                       input logic [1:0] f, input logic [7:0] m, input logic [7:0] n);
        clr = c_clr; push = c_push; pop = c_pop; top = c_top;
        flag_in = f; din_m = m; din_n = n;
        @(posedge clk);
        #1;
        clr = 0; push = 0; pop = 0; top = 0;
    endtask

    initial begin
        rst = 1'b0; clr = 0; push = 0; pop = 0; top = 0;
        flag_in = '0; din_m = '0; din_n = '0;
        #12;
        chk("rst.empty", 32'(empty), 1);
        chk("rst.full",  32'(full), 0);
        chk("rst.depth", 32'(depth), 0);
        chk("rst.max",   32'(max_depth), 0);
        chk("rst.ovf",   32'(ovf), 0);
        chk("rst.udf",   32'(udf), 0);
        chk_top("rst.top", 2'b00, 8'd0, 8'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        cyc(0, 1, 0, 0, FLG_INIT, 8'd3, 8'd5);
        chk_top("push1", FLG_INIT, 8'd3, 8'd5);
        chk("push1.depth", 32'(depth), 1);
        chk("push1.empty", 32'(empty), 0);

        cyc(0, 1, 0, 0, FLG_CALL, 8'd1, 8'd2);
        cyc(0, 1, 0, 0, FLG_RET0, 8'd7, 8'd9);
        chk_top("push3", FLG_RET0, 8'd7, 8'd9);
        chk("push3.depth", 32'(depth), 3);
        cyc(0, 0, 1, 0, 2'b00, 8'd0, 8'd0);
        chk_top("pop1", FLG_CALL, 8'd1, 8'd2);
        chk("pop1.depth", 32'(depth), 2);
        cyc(0, 0, 1, 0, 2'b00, 8'd0, 8'd0);
        chk_top("pop2", FLG_INIT, 8'd3, 8'd5);
        chk("pop2.depth", 32'(depth), 1);
        chk("pop2.max", 32'(max_depth), 3);
        cyc(0, 0, 1, 0, 2'b00, 8'd0, 8'd0);
        chk("pop3.empty", 32'(empty), 1);
        chk("pop3.udf", 32'(udf), 0);
        chk_top("pop3.top", 2'b00, 8'd0, 8'd0);

        cyc(0, 0, 1, 0, 2'b00, 8'd0, 8'd0);
        chk("udf_pop.udf", 32'(udf), 1);
        chk("udf_pop.depth", 32'(depth), 0);
        cyc(0, 1, 1, 0, FLG_CALL, 8'd6, 8'd6);
        chk("repl_empty.depth", 32'(depth), 1);
        chk_top("repl_empty", FLG_CALL, 8'd6, 8'd6);
        cyc(1, 0, 0, 0, 2'b00, 8'd0, 8'd0);
        chk("clr.depth", 32'(depth), 0);
        chk("clr.udf", 32'(udf), 0);
        chk("clr.ovf", 32'(ovf), 0);
        chk("clr.max", 32'(max_depth), 3);

        cyc(0, 0, 0, 1, 2'b00, 8'd0, 8'd0);
        chk("top_empty.udf", 32'(udf), 1);
        cyc(1, 1, 0, 0, FLG_RET1, 8'd9, 8'd9);
        chk("clr_push.depth", 32'(depth), 0);
        chk("clr_push.udf", 32'(udf), 0);

        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1, 0, 0, 2'(i), 8'(i), 8'(i + 100));
        end
        chk("fill.full", 32'(full), 1);
        chk("fill.depth", 32'(depth), 16);
        chk("fill.ovf", 32'(ovf), 0);
        chk("fill.max", 32'(max_depth), 16);
        cyc(0, 1, 0, 0, FLG_RET1, 8'hAA, 8'hBB);
        chk("ovf.ovf", 32'(ovf), 1);
        chk("ovf.depth", 32'(depth), 16);
        chk_top("ovf.top", 2'b00, 8'd16, 8'd116);
        cyc(0, 1, 1, 0, FLG_RET1, 8'd4, 8'd4);
        chk_top("repl_full", FLG_RET1, 8'd4, 8'd4);
        chk("repl_full.depth", 32'(depth), 16);
        chk("repl_full.ovf", 32'(ovf), 1);

        for (int i = 0; i < 11; i++) begin
            cyc(0, 0, 1, 0, 2'b00, 8'd0, 8'd0);
        end
        chk("drain.depth", 32'(depth), 5);
        chk_top("drain.top", 2'b01, 8'd5, 8'd105);

        clr = 0; push = 1; pop = 0; top = 1;
        flag_in = FLG_RET0; din_m = 8'h11; din_n = 8'h22;
        #2;
        chk_top("toppush.old", 2'b01, 8'd5, 8'd105);
        @(posedge clk); #1;
        push = 0; top = 0;
        chk_top("toppush.new", FLG_RET0, 8'h11, 8'h22);
        chk("toppush.depth", 32'(depth), 6);
        cyc(0, 0, 1, 0, 2'b00, 8'd0, 8'd0);
        chk("pre_rst.depth", 32'(depth), 5);

        #2;
        rst = 1'b0;
        #1;
        chk("arst.empty", 32'(empty), 1);
        chk("arst.depth", 32'(depth), 0);
        chk("arst.max", 32'(max_depth), 0);
        chk("arst.ovf", 32'(ovf), 0);
        chk_top("arst.top", 2'b00, 8'd0, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        cyc(0, 1, 0, 0, FLG_INIT, 8'd2, 8'd2);
        chk("post_rst.depth", 32'(depth), 1);
        chk("post_rst.max", 32'(max_depth), 1);
        chk_top("post_rst.top", FLG_INIT, 8'd2, 8'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
